// File: rtl/control_unit.sv
// Registered instruction decoder: 16-bit instruction -> datapath controls, RUN/HALTED FSM.
// Build option CU_SIGN_EXT_EN: sign-extend imm9 (default zero-extends).
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic [3:0]  flags,
  output logic [5:0]  alu_op,
  output logic        reg_write_en,
  output logic [2:0]  reg_sel,
  output logic        flag_write_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  pc_sel,
  output logic [15:0] immediate,
  output logic        use_immediate
);

  typedef enum logic {RUN, HALTED} state_e;

  typedef enum logic [5:0] {
    OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_MUL = 6'h03, OP_DIV = 6'h04,
    OP_MOD = 6'h05, OP_AND = 6'h06, OP_OR  = 6'h07, OP_XOR = 6'h08, OP_NOT = 6'h09,
    OP_LSL = 6'h0A, OP_LSR = 6'h0B, OP_RSL = 6'h0C, OP_RSR = 6'h0D, OP_MOV = 6'h0E,
    OP_INC = 6'h0F, OP_DEC = 6'h10, OP_CMP = 6'h11, OP_TST = 6'h12, OP_LDR = 6'h13,
    OP_STR = 6'h14, OP_BRZ = 6'h15, OP_BRN = 6'h16, OP_BRC = 6'h17, OP_BRO = 6'h18,
    OP_BRA = 6'h19, OP_HLT = 6'h1F
  } opcode_e;

  typedef enum logic [1:0] {PC_INC = 2'b00, PC_BRANCH = 2'b01, PC_HOLD = 2'b11} pcsel_e;

  state_e      state_q, state_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic        reg_write_en_q, reg_write_en_d;
  logic [2:0]  reg_sel_q, reg_sel_d;
  logic        flag_write_en_q, flag_write_en_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic [15:0] immediate_q, immediate_d;
  logic        use_immediate_q, use_immediate_d;

  logic [5:0]  opcode;
  logic [8:0]  imm9;
  logic        imm_nz;
  logic [15:0] imm_ext;

  assign opcode = instruction[15:10];
  assign imm9   = instruction[8:0];
  assign imm_nz = (imm9 != '0);
`ifdef CU_SIGN_EXT_EN
  assign imm_ext = {{7{imm9[8]}}, imm9};
`else
  assign imm_ext = {7'b0, imm9};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RUN;
      alu_op_q        <= '0;
      reg_write_en_q  <= 1'b0;
      reg_sel_q       <= '0;
      flag_write_en_q <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      pc_sel_q        <= PC_INC;
      immediate_q     <= '0;
      use_immediate_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      alu_op_q        <= alu_op_d;
      reg_write_en_q  <= reg_write_en_d;
      reg_sel_q       <= reg_sel_d;
      flag_write_en_q <= flag_write_en_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      pc_sel_q        <= pc_sel_d;
      immediate_q     <= immediate_d;
      use_immediate_q <= use_immediate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && opcode == OP_HLT) state_d = HALTED;
  end

  // HLT itself already holds the PC; while halted reg_sel/immediate keep their last values.
  always_comb begin
    alu_op_d        = '0;
    reg_write_en_d  = 1'b0;
    reg_sel_d       = {2'b00, instruction[9]};
    flag_write_en_d = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    pc_sel_d        = PC_INC;
    immediate_d     = imm_ext;
    use_immediate_d = 1'b0;
    if (state_q == HALTED) begin
      pc_sel_d    = PC_HOLD;
      reg_sel_d   = reg_sel_q;
      immediate_d = immediate_q;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR,
        OP_LSL, OP_LSR, OP_RSL, OP_RSR: begin
          alu_op_d        = opcode;
          reg_write_en_d  = 1'b1;
          flag_write_en_d = 1'b1;
          use_immediate_d = imm_nz;
        end
        OP_NOT, OP_INC, OP_DEC: begin
          alu_op_d        = opcode;
          reg_write_en_d  = 1'b1;
          flag_write_en_d = 1'b1;
        end
        OP_MOV: begin
          alu_op_d        = opcode;
          reg_write_en_d  = 1'b1;
          use_immediate_d = imm_nz;
        end
        OP_CMP, OP_TST: begin
          alu_op_d        = opcode;
          flag_write_en_d = 1'b1;
          use_immediate_d = imm_nz;
        end
        OP_LDR: begin
          mem_read_d      = 1'b1;
          reg_write_en_d  = 1'b1;
          use_immediate_d = 1'b1;
        end
        OP_STR: begin
          mem_write_d     = 1'b1;
          use_immediate_d = 1'b1;
        end
        OP_BRZ: begin pc_sel_d = flags[0] ? PC_BRANCH : PC_INC; use_immediate_d = 1'b1; end
        OP_BRN: begin pc_sel_d = flags[1] ? PC_BRANCH : PC_INC; use_immediate_d = 1'b1; end
        OP_BRC: begin pc_sel_d = flags[2] ? PC_BRANCH : PC_INC; use_immediate_d = 1'b1; end
        OP_BRO: begin pc_sel_d = flags[3] ? PC_BRANCH : PC_INC; use_immediate_d = 1'b1; end
        OP_BRA: begin pc_sel_d = PC_BRANCH; use_immediate_d = 1'b1; end
        OP_HLT: pc_sel_d = PC_HOLD;
        default: ;
      endcase
    end
  end

  assign alu_op        = alu_op_q;
  assign reg_write_en  = reg_write_en_q;
  assign reg_sel       = reg_sel_q;
  assign flag_write_en = flag_write_en_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign pc_sel        = pc_sel_q;
  assign immediate     = immediate_q;
  assign use_immediate = use_immediate_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver pushes model predictions, monitor pops and compares.
module tb_control_unit;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic        rw;
    logic [2:0]  rs;
    logic        fw;
    logic        mr;
    logic        mw;
    logic [1:0]  pc;
    logic [15:0] imm;
    logic        ui;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = '0;
  logic [3:0]  flags = '0;
  logic [5:0]  alu_op;
  logic        reg_write_en, flag_write_en, mem_read, mem_write, use_immediate;
  logic [2:0]  reg_sel;
  logic [1:0]  pc_sel;
  logic [15:0] immediate;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .flags(flags),
    .alu_op(alu_op), .reg_write_en(reg_write_en), .reg_sel(reg_sel),
    .flag_write_en(flag_write_en), .mem_read(mem_read), .mem_write(mem_write),
    .pc_sel(pc_sel), .immediate(immediate), .use_immediate(use_immediate)
  );

  always #5 clk = ~clk;

  exp_t        expq[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          m_halted = 1'b0;
  logic [15:0] m_imm = '0;
  logic [2:0]  m_rs = '0;

  function automatic logic [15:0] ext(input logic [8:0] v);
`ifdef CU_SIGN_EXT_EN
    return {{7{v[8]}}, v};
`else
    return {7'b0, v};
`endif
  endfunction

  // Reference model: instruction classes by opcode number ranges.
  function automatic exp_t model(input logic r, input logic [15:0] ins, input logic [3:0] f);
    exp_t e;
    int unsigned op;
    logic nz;
    e = '0;
    op = int'(ins[15:10]);
    nz = (ins[8:0] != 9'd0);
    if (!r) begin
      m_halted = 1'b0; m_imm = '0; m_rs = '0;
      return e;
    end
    if (m_halted) begin
      e.pc = 2'b11; e.imm = m_imm; e.rs = m_rs;
      return e;
    end
    e.imm = ext(ins[8:0]);
    e.rs  = {2'b00, ins[9]};
    if ((op >= 1 && op <= 8) || (op >= 10 && op <= 13)) begin
      e.alu_op = ins[15:10]; e.rw = 1; e.fw = 1; e.ui = nz;
    end else if (op == 9 || op == 15 || op == 16) begin
      e.alu_op = ins[15:10]; e.rw = 1; e.fw = 1;
    end else if (op == 14) begin
      e.alu_op = ins[15:10]; e.rw = 1; e.ui = nz;
    end else if (op == 17 || op == 18) begin
      e.alu_op = ins[15:10]; e.fw = 1; e.ui = nz;
    end else if (op == 19) begin
      e.mr = 1; e.rw = 1; e.ui = 1;
    end else if (op == 20) begin
      e.mw = 1; e.ui = 1;
    end else if (op >= 21 && op <= 24) begin
      e.pc = f[op-21] ? 2'b01 : 2'b00; e.ui = 1;
    end else if (op == 25) begin
      e.pc = 2'b01; e.ui = 1;
    end else if (op == 31) begin
      e.pc = 2'b11; m_halted = 1'b1;
    end
    m_imm = e.imm;
    m_rs  = e.rs;
    return e;
  endfunction

  function automatic logic [15:0] mk(input logic [5:0] op, input logic r, input logic [8:0] imm);
    return {op, r, imm};
  endfunction

  task automatic step(input logic r, input logic [15:0] ins, input logic [3:0] f);
    @(negedge clk);
    rst_n = r; instruction = ins; flags = f;
    expq.push_back(model(r, ins, f));
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{alu_op, reg_write_en, reg_sel, flag_write_en, mem_read, mem_write,
              pc_sel, immediate, use_immediate};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d ins=%h: got alu=%h rw=%b rs=%h fw=%b mr=%b mw=%b pc=%b imm=%h ui=%b, exp alu=%h rw=%b rs=%h fw=%b mr=%b mw=%b pc=%b imm=%h ui=%b",
                   vectors, instruction, a.alu_op, a.rw, a.rs, a.fw, a.mr, a.mw, a.pc, a.imm, a.ui,
                   e.alu_op, e.rw, e.rs, e.fw, e.mr, e.mw, e.pc, e.imm, e.ui);
        end
        if (mem_read && mem_write) begin
          miscompares++;
          $display("FAIL memrw_exclusive: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] op;
    int unsigned wait_cycles;
    step(0, 16'h0000, 4'h0);
    step(0, 16'hFFFF, 4'hF);
    step(1, mk(6'h01, 0, 9'h000), 4'h0);
    step(1, mk(6'h01, 0, 9'h189), 4'h0);
    step(1, mk(6'h0F, 0, 9'h123), 4'h0);
    step(1, mk(6'h10, 0, 9'h056), 4'h0);
    step(1, mk(6'h11, 1, 9'h000), 4'h0);
    step(1, mk(6'h11, 1, 9'h123), 4'h0);
    step(1, mk(6'h15, 0, 9'h010), 4'b0001);
    step(1, mk(6'h15, 0, 9'h010), 4'b0000);
    step(1, mk(6'h13, 1, 9'h1FF), 4'h0);
    step(1, mk(6'h14, 0, 9'h004), 4'h0);
    step(1, mk(6'h19, 0, 9'h100), 4'h0);
    step(1, mk(6'h09, 1, 9'h0AA), 4'h0);
    step(1, mk(6'h0E, 0, 9'h000), 4'h0);
    step(1, mk(6'h1A, 1, 9'h155), 4'hF);
    step(1, mk(6'h1F, 1, 9'h1C3), 4'h0);
    step(1, mk(6'h01, 0, 9'h005), 4'h0);
    step(1, mk(6'h19, 0, 9'h005), 4'hF);
    step(0, mk(6'h01, 0, 9'h005), 4'h0);
    step(1, mk(6'h01, 0, 9'h005), 4'h0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 85) op = 6'($urandom_range(25));
      else op = 6'($urandom_range(63));
      step(($urandom_range(99) < 4) ? 1'b0 : 1'b1,
           mk(op, 1'($urandom), 9'($urandom)), 4'($urandom));
    end
    @(negedge clk);
    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (expq.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d pending, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
